// File: rtl/game_tick_pkg.sv
// Shared types for the game tick scheduler: control/arbiter states, level encoding
// and the tick period for each speed level.
package game_tick_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned LEVEL_W  = 2;
  localparam int unsigned PERIOD_W = 32;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_RUN   = 2'd1,
    CTRL_PAUSE = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic [LEVEL_W-1:0] {
    LEVEL_SLOW   = 2'd0,
    LEVEL_NORMAL = 2'd1,
    LEVEL_FAST   = 2'd2,
    LEVEL_TURBO  = 2'd3
  } level_t;

  // Tick period in clock cycles; higher levels tick faster.
  function automatic logic [PERIOD_W-1:0] period_for_level(input level_t level,
                                                           input logic [PERIOD_W-1:0] freq);
    logic [PERIOD_W-1:0] period;
    case (level)
      LEVEL_SLOW:   period = freq << 2;
      LEVEL_NORMAL: period = freq << 1;
      LEVEL_FAST:   period = freq;
      LEVEL_TURBO:  period = freq >> 1;
      default:      period = freq << 2;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// Base-rate down-counter: reloads period-1 while loading or on expiry, counts in run,
// freezes otherwise; tick decodes counter==0 while running.
module tick_divider
  import game_tick_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
  input  logic   ClockIn,
  input  logic   Reset,
  input  level_t level,
  input  logic   run,
  input  logic   load,
  output logic   tick
);

  localparam logic [PERIOD_W-1:0] FREQ        = PERIOD_W'(CLOCK_FREQUENCY);
  localparam logic [PERIOD_W-1:0] RESET_COUNT = period_for_level(LEVEL_SLOW, FREQ) - PERIOD_W'(1);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] count_d;
  logic [PERIOD_W-1:0] reload;

  assign reload = period_for_level(level, FREQ) - PERIOD_W'(1);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = reload;
    end else if (run) begin
      count_d = (count_q == '0) ? reload : count_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      count_q <= RESET_COUNT;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = run && (count_q == '0);

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: IDLE/RUN/PAUSE control, base-rate tick, round-robin update grant.
// Optional automatic level ramp enabled by defining GAME_TICK_LEVEL_RAMP_EN.
module game_tick_scheduler
  import game_tick_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned TICKS_PER_LEVEL = 16
) (
  input  logic               ClockIn,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Pause,
  input  logic               Stop,
  input  logic [LEVEL_W-1:0] SpeedSel,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] Done,
  output logic [NUM_REQ-1:0] Grant,
  output logic               Tick,
  output logic [LEVEL_W-1:0] Level,
  output logic               Overrun,
  output logic [1:0]         RunState
);

  if (CLOCK_FREQUENCY < 2) begin : g_bad_freq
    $error("CLOCK_FREQUENCY must be at least 2");
  end
  if (TICKS_PER_LEVEL < 1) begin : g_bad_ramp
    $error("TICKS_PER_LEVEL must be at least 1");
  end

  ctrl_state_t        state_q, state_d;
  arb_state_t         arb_q, arb_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               overrun_q, overrun_d;
  level_t             level_q, level_d;
  level_t             divider_level;
  logic               tick;
  logic               start_run;
  logic               done_hit;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  // Control FSM; Stop wins over Start and Pause.
  always_comb begin
    state_d = state_q;
    if (Stop) begin
      state_d = CTRL_IDLE;
    end else begin
      case (state_q)
        CTRL_IDLE:  if (Start) state_d = CTRL_RUN;
        CTRL_RUN:   if (Pause) state_d = CTRL_PAUSE;
        CTRL_PAUSE: if (Pause) state_d = CTRL_RUN;
        default:    state_d = CTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign start_run = (state_q == CTRL_IDLE) && (state_d == CTRL_RUN);

  tick_divider #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_tick_divider (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .level   (divider_level),
    .run     (state_q == CTRL_RUN),
    .load    (state_q == CTRL_IDLE),
    .tick    (tick)
  );

  // Round-robin search starting just after the last granted index.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = IDX_W'(int'(last_q) + i);
      if (!pick_found && Req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign done_hit = |(Done & grant_q);

  // Arbiter FSM; a Done on the granted index frees the slot in the same cycle as a Tick.
  always_comb begin
    arb_d     = arb_q;
    grant_d   = grant_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    if (Stop) begin
      arb_d     = ARB_FREE;
      grant_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if ((arb_q == ARB_BUSY) && done_hit) begin
        arb_d   = ARB_FREE;
        grant_d = '0;
      end
      if (tick) begin
        if ((arb_q == ARB_BUSY) && !done_hit) begin
          overrun_d = 1'b1;
        end else if (pick_found) begin
          arb_d   = ARB_BUSY;
          grant_d = NUM_REQ'(1) << pick_idx;
          last_d  = pick_idx;
        end
      end
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      arb_q     <= ARB_FREE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      overrun_q <= 1'b0;
    end else begin
      arb_q     <= arb_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef GAME_TICK_LEVEL_RAMP_EN
  localparam int unsigned RAMP_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

  logic [RAMP_W-1:0] ramp_q, ramp_d;

  // Level ramp: restart at the slowest level on Start, step every TICKS_PER_LEVEL ticks.
  always_comb begin
    level_d = level_q;
    ramp_d  = ramp_q;
    if (Stop) begin
      ramp_d = '0;
    end else if (start_run) begin
      level_d = LEVEL_SLOW;
      ramp_d  = '0;
    end else if (tick) begin
      if (ramp_q == RAMP_W'(TICKS_PER_LEVEL - 1)) begin
        ramp_d = '0;
        if (level_q != LEVEL_TURBO) level_d = level_t'(level_q + 2'd1);
      end else begin
        ramp_d = ramp_q + RAMP_W'(1);
      end
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  // An idle counter preloads the slowest period, the level every run starts from.
  assign divider_level = (state_q == CTRL_IDLE) ? LEVEL_SLOW : level_q;
`else
  always_comb begin
    level_d = level_t'(SpeedSel);
  end

  assign divider_level = level_q;
`endif

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      level_q <= LEVEL_SLOW;
    end else begin
      level_q <= level_d;
    end
  end

  assign Grant    = grant_q;
  assign Tick     = tick;
  assign Level    = level_q;
  assign Overrun  = overrun_q;
  assign RunState = state_q;

endmodule
